booth_mul_sched: RTL and testbench



---
 rtl/booth_mul_sched.sv | 218 +++++++++++++++++++++
 tb/tb_booth_mul_sched.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_sched.sv
// booth_mul_sched
//   Radix-4 Booth multiply scheduler. Two requesters share one iterative
//   signed multiply engine. One Booth digit is retired per clock. The
//   full-width product is returned with the requester ID.
//
//   Parameter W (even, >= 4): operand width. Product width is 2W.
//
//   Ports:
//     clk, rst_n                  clock, asynchronous active-low reset
//     req0_valid/ready/a/b        requester 0 operand port (valid/ready)
//     req1_valid/ready/a/b        requester 1 operand port (valid/ready)
//     rsp_valid/ready             product handshake
//     rsp_product [2W-1:0]        signed product A*B
//     rsp_id                      requester that issued the product
//     busy                        engine occupied (RUN or DONE)
//
//   Build option: define BOOTH_SCHED_FIXED_PRIO_EN for fixed priority.
//   Requester 0 then always wins ties. Round-robin is the default.
module booth_mul_sched #(
  parameter int W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [W-1:0]    req0_a,
  input  logic [W-1:0]    req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [W-1:0]    req1_a,
  input  logic [W-1:0]    req1_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [2*W-1:0]  rsp_product,
  output logic            rsp_id,
  output logic            busy
);

  localparam int PW = 2 * W;
  localparam int ND = W / 2;
  localparam int CW = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(ND - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic            id_r;
  logic [PW-1:0]   acc_r;
  logic [CW-1:0]   cnt_r;
  logic            rsp_valid_r;
  logic [PW-1:0]   rsp_product_r;
  logic            rsp_id_r;
  logic            busy_r;
`ifndef BOOTH_SCHED_FIXED_PRIO_EN
  logic            rr_last_r;
`endif

  logic            grant_s;
  logic            req0_ready_s;
  logic            req1_ready_s;
  logic            accept_s;
  logic            accept_id_s;
  logic [W-1:0]    accept_a_s;
  logic [W-1:0]    accept_b_s;
  logic [W:0]      b_ext_s;
  logic [W:0]      b_shift_s;
  logic [2:0]      triplet_s;
  logic [PW-1:0]   a_sx_s;
  logic [PW-1:0]   pp_s;
  logic [PW-1:0]   shifted_s;
  logic [PW-1:0]   sum_s;

  // Arbitration: pick which requester would be accepted this cycle.
  always_comb begin
    grant_s = 1'b0;
`ifdef BOOTH_SCHED_FIXED_PRIO_EN
    if (req0_valid) begin
      grant_s = 1'b0;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
`else
    if (req0_valid && req1_valid) begin
      grant_s = ~rr_last_r;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
`endif
  end

  // Ready generation; rst_n gates the readies so they drop the moment reset asserts.
  always_comb begin
    req0_ready_s = 1'b0;
    req1_ready_s = 1'b0;
    if (rst_n && (state_r == IDLE)) begin
      req0_ready_s = ~grant_s;
      req1_ready_s = grant_s;
    end else begin
      req0_ready_s = 1'b0;
      req1_ready_s = 1'b0;
    end
  end

  // Accept decode and operand selection for the winning port.
  always_comb begin
    accept_s    = (req0_valid & req0_ready_s) | (req1_valid & req1_ready_s);
    accept_id_s = req1_valid & req1_ready_s;
    if (accept_id_s) begin
      accept_a_s = req1_a;
      accept_b_s = req1_b;
    end else begin
      accept_a_s = req0_a;
      accept_b_s = req0_b;
    end
  end

  // Booth digit datapath: recode the current triplet and form the shifted partial product.
  always_comb begin
    // The appended zero is B[-1], so digit i sits at bits [2i+2:2i].
    b_ext_s   = {b_r, 1'b0};
    b_shift_s = b_ext_s >> {cnt_r, 1'b0};
    triplet_s = b_shift_s[2:0];
    // Sign-extend before any negation so -2A of the most-negative A is exact.
    a_sx_s    = {{W{a_r[W-1]}}, a_r};
    case (triplet_s)
      3'b000, 3'b111: pp_s = {PW{1'b0}};
      3'b001, 3'b010: pp_s = a_sx_s;
      3'b011:         pp_s = {a_sx_s[PW-2:0], 1'b0};
      3'b100:         pp_s = -{a_sx_s[PW-2:0], 1'b0};
      3'b101, 3'b110: pp_s = -a_sx_s;
      default:        pp_s = {PW{1'b0}};
    endcase
    shifted_s = pp_s << {cnt_r, 1'b0};
    sum_s     = acc_r + shifted_s;
  end

  // Control FSM with datapath registers and registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      a_r           <= {W{1'b0}};
      b_r           <= {W{1'b0}};
      id_r          <= 1'b0;
      acc_r         <= {PW{1'b0}};
      cnt_r         <= {CW{1'b0}};
      rsp_valid_r   <= 1'b0;
      rsp_product_r <= {PW{1'b0}};
      rsp_id_r      <= 1'b0;
      busy_r        <= 1'b0;
`ifndef BOOTH_SCHED_FIXED_PRIO_EN
      rr_last_r     <= 1'b1;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r       <= accept_a_s;
            b_r       <= accept_b_s;
            id_r      <= accept_id_s;
            acc_r     <= {PW{1'b0}};
            cnt_r     <= {CW{1'b0}};
            busy_r    <= 1'b1;
            state_r   <= RUN;
`ifndef BOOTH_SCHED_FIXED_PRIO_EN
            rr_last_r <= accept_id_s;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          acc_r <= sum_s;
          if (cnt_r == LAST_DIGIT) begin
            // Product is copied out so it survives the next accept clearing acc_r.
            rsp_product_r <= sum_s;
            rsp_id_r      <= id_r;
            rsp_valid_r   <= 1'b1;
            state_r       <= DONE;
          end else begin
            cnt_r <= cnt_r + CW'(1'b1);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign req0_ready  = req0_ready_s;
  assign req1_ready  = req1_ready_s;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_product = rsp_product_r;
  assign rsp_id      = rsp_id_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_booth_mul_sched.sv
// Self-checking bench for booth_mul_sched (W = 16). Expected products come
// from plain signed multiplication; expected IDs come from a simple
// alternating or fixed-priority arbitration model.
module tb_booth_mul_sched;

  localparam int W  = 16;
  localparam int PW = 32;

  logic          clk;
  logic          rst_n;
  logic          req0_valid, req0_ready;
  logic [W-1:0]  req0_a, req0_b;
  logic          req1_valid, req1_ready;
  logic [W-1:0]  req1_a, req1_b;
  logic          rsp_valid, rsp_ready;
  logic [PW-1:0] rsp_product;
  logic          rsp_id;
  logic          busy;

  int errors = 0;
  int checks = 0;

  booth_mul_sched #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_product (rsp_product),
    .rsp_id      (rsp_id),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact signed product truncated to 2W bits.
  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = sa * sb;
    return p[PW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
  endtask

  // Issue one request on port id and wait for its response; lat = -1 on timeout.
  task automatic run_one(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [PW-1:0] p, output logic rid, output int lat);
    int k;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    #1;
    k = 0;
    while (!(id ? req1_ready : req0_ready) && k < 20) begin tick(); k++; end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin tick(); lat++; end
    if (!rsp_valid) lat = -1;
    p = rsp_product; rid = rsp_id;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    tick(); tick();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_product !== 32'h0 || rsp_id !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b prod=%h id=%b busy=%b, required 0/0/0/0",
               rsp_valid, rsp_product, rsp_id, busy);
    end
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_readies: r0=%b r1=%b, required 0 0", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_basic();
    int lat;
    req0_valid = 1'b1; req0_a = 16'd3; req0_b = 16'd5;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_ready: r0=%b r1=%b, required 1 0", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: busy=%b, required 1", busy);
    end
    lat = 0;
    while (!rsp_valid && lat < 40) begin tick(); lat++; end
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles, required 8", lat);
    end
    checks++;
    if (rsp_product !== 32'h0000000F || rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL basic_product: got %h id %b, required 0000000f id 0", rsp_product, rsp_id);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_corners();
    logic [W-1:0]  ta [4];
    logic [W-1:0]  tb [4];
    logic [PW-1:0] te [4];
    logic [PW-1:0] p;
    logic          rid;
    int            lat;
    ta[0] = 16'h8000; tb[0] = 16'h8000; te[0] = 32'h40000000;
    ta[1] = 16'h8000; tb[1] = 16'h7FFF; te[1] = 32'hC0008000;
    ta[2] = 16'h7FFF; tb[2] = 16'h7FFF; te[2] = 32'h3FFF0001;
    ta[3] = 16'hFFFF; tb[3] = 16'hFFFF; te[3] = 32'h00000001;
    for (int i = 0; i < 4; i++) begin
      run_one(1'b0, ta[i], tb[i], p, rid, lat);
      checks++;
      if (p !== te[i] || lat !== 8) begin
        errors++;
        $display("FAIL corner_%0d: got %h lat %0d, required %h lat 8", i, p, lat, te[i]);
      end
    end
  endtask

  task automatic test_arbitration();
    logic [W-1:0]  a0, b0, a1, b1;
    logic          exp_id;
    logic [PW-1:0] exp_p;
    int            got, cyc;
    do_reset();
    a0 = 16'hFF9C; b0 = 16'd77; a1 = 16'd1234; b1 = 16'hFC18;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    got = 0; cyc = 0;
    while (got < 4 && cyc < 200) begin
      tick(); cyc++;
      if (rsp_valid) begin
`ifdef BOOTH_SCHED_FIXED_PRIO_EN
        exp_id = 1'b0;
`else
        exp_id = got[0];
`endif
        exp_p = exp_id ? ref_mul(a1, b1) : ref_mul(a0, b0);
        checks++;
        if (rsp_id !== exp_id || rsp_product !== exp_p) begin
          errors++;
          $display("FAIL arb_rsp_%0d: got id %b prod %h, required id %b prod %h",
                   got, rsp_id, rsp_product, exp_id, exp_p);
        end
        got++;
      end
    end
    checks++;
    if (got !== 4) begin
      errors++;
      $display("FAIL arb_count: got %0d responses, required 4", got);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc = 0;
    while (busy && cyc < 40) begin tick(); cyc++; end
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [W-1:0]  a, b;
    logic [PW-1:0] exp_p;
    int            lat;
    a = 16'($urandom); b = 16'($urandom);
    exp_p = ref_mul(a, b);
    req1_valid = 1'b1; req1_a = a; req1_b = b;
    #1;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin tick(); lat++; end
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_product !== exp_p || rsp_id !== 1'b1 || busy !== 1'b1 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: v=%b p=%h id=%b busy=%b r0=%b r1=%b, required 1 %h 1 1 0 0",
                 i, rsp_valid, rsp_product, rsp_id, busy, req0_ready, req1_ready, exp_p);
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req0_ready !== 1'b1 ||
        rsp_product !== exp_p || rsp_id !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: v=%b busy=%b r0=%b p=%h id=%b, required 0 0 1 %h 1",
               rsp_valid, busy, req0_ready, rsp_product, rsp_id, exp_p);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [PW-1:0] p;
    logic          rid;
    int            lat, seen;
    req0_valid = 1'b1; req0_a = 16'd100; req0_b = 16'hFFFD;
    #1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_product !== 32'h0 || rsp_id !== 1'b0 || busy !== 1'b0 ||
        req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: v=%b p=%h id=%b busy=%b r0=%b r1=%b, required all 0",
               rsp_valid, rsp_product, rsp_id, busy, req0_ready, req1_ready);
    end
    req0_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midrst_no_rsp: saw %0d valid cycles, required 0", seen);
    end
    run_one(1'b0, 16'hFFFE, 16'd9, p, rid, lat);
    checks++;
    if (p !== 32'hFFFFFFEE || rid !== 1'b0 || lat !== 8) begin
      errors++;
      $display("FAIL midrst_new: got %h id %b lat %0d, required ffffffee id 0 lat 8", p, rid, lat);
    end
  endtask

  task automatic test_random_sweep();
    logic [PW-1:0] q0[$];
    logic [PW-1:0] q1[$];
    logic [PW-1:0] exp_p;
    int  issued0, issued1, received, cyc;
    logic acc0, acc1;
    issued0 = 0; issued1 = 0; received = 0; cyc = 0;
    acc0 = 1'b0; acc1 = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    while (received < 1000 && cyc < 40000) begin
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
      if (!req0_valid && issued0 < 500 && $urandom_range(0, 1) == 1) begin
        req0_valid = 1'b1; req0_a = 16'($urandom); req0_b = 16'($urandom);
      end
      if (!req1_valid && issued1 < 500 && $urandom_range(0, 1) == 1) begin
        req1_valid = 1'b1; req1_a = 16'($urandom); req1_b = 16'($urandom);
      end
      rsp_ready = 1'($urandom_range(0, 1));
      #1;
      acc0 = req0_valid & req0_ready;
      acc1 = req1_valid & req1_ready;
      if (acc0) begin q0.push_back(ref_mul(req0_a, req0_b)); issued0++; end
      if (acc1) begin q1.push_back(ref_mul(req1_a, req1_b)); issued1++; end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if ((rsp_id ? q1.size() : q0.size()) == 0) begin
          errors++;
          $display("FAIL sweep_extra: unexpected product %h for id %b", rsp_product, rsp_id);
        end else begin
          exp_p = rsp_id ? q1.pop_front() : q0.pop_front();
          if (rsp_product !== exp_p) begin
            errors++;
            $display("FAIL sweep_product: id %b got %h, required %h", rsp_id, rsp_product, exp_p);
          end
        end
        received++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    checks++;
    if (received !== 1000 || q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL sweep_count: received %0d pending %0d/%0d, required 1000 and 0/0",
               received, q0.size(), q1.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_arbitration();
    test_backpressure();
    test_reset_mid_run();
    test_random_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
